// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell processes a bit pair per clock,
// LSB first, with the carry held in a flop between bits.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; sum/cout hold the last completed result
// ST_RUN  | one bit pair per clock through the cell, WIDTH clocks total

module fulladd (
   input  logic a,
   input  logic b,
   input  logic Cin,
   output logic Sum,
   output logic Carry
);
   assign Sum   = a ^ b ^ Cin;
   assign Carry = (a & b) | (Cin & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int            CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LP_LAST = CW'(WIDTH - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_s_sh;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_done;

   logic             w_accept;
   logic             w_step;
   logic             w_last;
   logic             w_busy;
   logic             w_fa_sum;
   logic             w_fa_carry;
   logic [WIDTH-1:0] w_s_nxt;

   fulladd u_fa (
      .a     (r_a_sh[0]),
      .b     (r_b_sh[0]),
      .Cin   (r_c),
      .Sum   (w_fa_sum),
      .Carry (w_fa_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start)  w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last) w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_busy   = (r_state == ST_RUN);
      w_accept = (r_state == ST_IDLE) && start;
      w_step   = (r_state == ST_RUN);
      w_last   = (r_state == ST_RUN) && (r_cnt == LP_LAST);
   end

   // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
   always_comb begin
      w_s_nxt            = r_s_sh >> 1;
      w_s_nxt[WIDTH-1]   = w_fa_sum;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh <= '0;
         r_b_sh <= '0;
         r_s_sh <= '0;
         r_c    <= 1'b0;
         r_cnt  <= '0;
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_c    <= cin;
            r_cnt  <= '0;
         end else if (w_step) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_s_sh <= w_s_nxt;
            r_c    <= w_fa_carry;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
               r_sum  <= w_s_nxt;
               r_cout <= w_fa_carry;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign busy = w_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and back-to-back random checks of serial_adder at WIDTH=8 and WIDTH=1.

module tb_serial_adder;
   logic       clk = 1'b0;
   logic       rst;

   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;

   logic       start1, cin1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_add8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ic, input logic [7:0] es, input logic ec);
      logic [7:0] prior_sum;
      logic       prior_cout;
      int         nb, nd;
      logic       hold_ok;
      prior_sum  = sum8;
      prior_cout = cout8;
      @(negedge clk);
      a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      nb = 0; nd = 0; hold_ok = 1'b1;
      repeat (8) begin
         if (busy8) nb++;
         if (done8) nd++;
         if (sum8 !== prior_sum || cout8 !== prior_cout) hold_ok = 1'b0;
         @(negedge clk);
      end
      chk({tag, "_busycnt"}, nb, 8);
      chk({tag, "_early_done"}, nd, 0);
      chk({tag, "_hold"}, hold_ok, 1);
      chk({tag, "_done"}, done8, 1);
      chk({tag, "_busy_end"}, busy8, 0);
      chk({tag, "_sum"}, sum8, es);
      chk({tag, "_cout"}, cout8, ec);
   endtask

   task automatic do_add1(input string tag, input logic ia, input logic ib, input logic ic,
                          input logic es, input logic ec);
      @(negedge clk);
      a1 = ia; b1 = ib; cin1 = ic; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk({tag, "_busy"}, busy1, 1);
      chk({tag, "_nodone"}, done1, 0);
      @(negedge clk);
      chk({tag, "_done"}, done1, 1);
      chk({tag, "_idle"}, busy1, 0);
      chk({tag, "_sum"}, sum1, es);
      chk({tag, "_cout"}, cout1, ec);
   endtask

   initial begin
      logic [7:0] cur_a, cur_b, cap_sum;
      logic       cur_c, cap_cout;
      logic [8:0] exp9;
      int         cyc, nd, first;

      rst = 1'b1;
      start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
      repeat (2) @(negedge clk);
      // start was high throughout reset and must not have been taken
      chk("rst_busy8", busy8, 0);
      chk("rst_done8", done8, 0);
      chk("rst_sum8", sum8, 0);
      chk("rst_cout8", cout8, 0);
      chk("rst_busy1", busy1, 0);
      chk("rst_done1", done1, 0);
      chk("rst_sum1", sum1, 0);
      chk("rst_cout1", cout1, 0);
      rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
      @(negedge clk);
      chk("idle_after_rst", busy8, 0);

      do_add8("add_3c_5a", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0);
      do_add8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      do_add8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

      // second start during busy cycle 3 must be ignored
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      nd = 0; first = 0; cap_sum = 8'h00; cap_cout = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (done8) begin
            nd++;
            if (first == 0) begin
               first = k; cap_sum = sum8; cap_cout = cout8;
            end
         end
         if (k == 3) begin
            a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
      end
      chk("coll_ndone", nd, 1);
      chk("coll_latency", first, 9);
      chk("coll_sum", cap_sum, 8'h30);
      chk("coll_cout", cap_cout, 0);

      // reset at busy cycle 4 aborts the operation
      a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", busy8, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy8, 0);
      chk("abort_sum", sum8, 0);
      chk("abort_cout", cout8, 0);
      chk("abort_done", done8, 0);
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) nd++;
      end
      chk("abort_no_done", nd, 0);
      do_add8("add_01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

      // back-to-back random, start re-asserted in each done cycle
      @(negedge clk);
      cur_a = 8'($urandom); cur_b = 8'($urandom); cur_c = 1'($urandom);
      a8 = cur_a; b8 = cur_b; cin8 = cur_c; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      cyc = 1;
      for (int i = 0; i < 1000; i++) begin
         while (!done8 && cyc < 20) begin
            @(negedge clk);
            cyc++;
         end
         exp9 = {1'b0, cur_a} + {1'b0, cur_b} + {8'h00, cur_c};
         chk("rnd_done", done8, 1);
         chk("rnd_gap", cyc, 9);
         chk("rnd_result", {cout8, sum8}, exp9);
         if (!done8) break;
         if (i < 999) begin
            cur_a = 8'($urandom); cur_b = 8'($urandom); cur_c = 1'($urandom);
            a8 = cur_a; b8 = cur_b; cin8 = cur_c; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom);
            cyc = 1;
         end
      end

      do_add1("w1_111", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      do_add1("w1_100", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      do_add1("w1_000", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_add1("w1_011", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
